// File: rtl/multi_channel_period_meter.sv
// multi_channel_period_meter
// Measures the clk-cycle period between rising edges on NUM_CH asynchronous
// tachometer inputs. Each channel has its own synchroniser, edge detector,
// period counter with stall timeout, and a sliding-window period average.

module multi_channel_period_meter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1_000_000,
  parameter int AVG_LOG2    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       rpm_signal,
  output logic [NUM_CH*CNT_W-1:0] time_period,
  output logic [NUM_CH-1:0]       period_valid,
  output logic [NUM_CH*CNT_W-1:0] avg_period,
  output logic [NUM_CH-1:0]       avg_valid,
  output logic [NUM_CH-1:0]       stalled
);

  localparam int DEPTH       = 1 << AVG_LOG2;
  localparam int PW          = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DEPTH_ALLOC = 1 << PW;
  localparam int SW          = CNT_W + AVG_LOG2;
  localparam int FW          = AVG_LOG2 + 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_det;
    logic [0:0]             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       tp_q;
    logic                   pv_q;
    logic [CNT_W-1:0]       avg_q;
    logic                   av_q;
    logic                   st_q;
    logic [CNT_W-1:0]       win_q [DEPTH_ALLOC];
    logic [PW-1:0]          wr_ptr_q;
    logic [FW-1:0]          fill_q;
    logic [SW-1:0]          sum_q;
    logic [SW-1:0]          sum_next;
    logic [CNT_W-1:0]       oldest;
    logic                   full_next;
    logic                   accept;
    logic                   timeout_hit;
    logic                   win_clear;

    // Synchroniser chain plus history flop; runs regardless of enable/reset so
    // a level that is already high when measurement resumes is not an edge.
    always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rpm_signal[ch]};
      hist_q <= sync_q[SYNC_STAGES-1];
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Decode the events of this cycle and precompute the next window sum.
    always_comb begin
      accept      = 1'b0;
      timeout_hit = 1'b0;
      oldest      = win_q[wr_ptr_q];
      sum_next    = sum_q + SW'(cnt_q) - SW'(oldest);
      full_next   = (fill_q >= FW'(DEPTH - 1));
      if (enable && (state_q == MEASURE)) begin
        accept      = edge_det;
        timeout_hit = !edge_det && (cnt_q == CNT_W'(TIMEOUT));
      end
      win_clear = rst || !enable || timeout_hit;
    end

    // Circular buffer of the most recent periods with its running sum.
    always_ff @(posedge clk) begin
      if (win_clear) begin
        for (int i = 0; i < DEPTH_ALLOC; i++) win_q[i] <= '0;
        wr_ptr_q <= '0;
        fill_q   <= '0;
        sum_q    <= '0;
      end else if (accept) begin
        win_q[wr_ptr_q] <= cnt_q;
        sum_q           <= sum_next;
        wr_ptr_q        <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        fill_q          <= full_next ? FW'(DEPTH) : fill_q + 1'b1;
      end
    end

    // Per-channel FSM: period counting, reporting, stall detection.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tp_q    <= '0;
        pv_q    <= 1'b0;
        avg_q   <= '0;
        av_q    <= 1'b0;
        st_q    <= 1'b0;
      end else if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pv_q    <= 1'b0;
        avg_q   <= '0;
        av_q    <= 1'b0;
        st_q    <= 1'b0;
      end else begin
        pv_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (edge_det) begin
              cnt_q   <= CNT_W'(1);
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (accept) begin
              tp_q  <= cnt_q;
              pv_q  <= 1'b1;
              cnt_q <= CNT_W'(1);
              st_q  <= 1'b0;
              if (full_next) begin
                av_q  <= 1'b1;
                avg_q <= CNT_W'(sum_next >> AVG_LOG2);
              end
            end else if (timeout_hit) begin
              st_q    <= 1'b1;
              tp_q    <= '0;
              av_q    <= 1'b0;
              avg_q   <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign time_period[ch*CNT_W +: CNT_W] = tp_q;
    assign avg_period[ch*CNT_W +: CNT_W]  = avg_q;
    assign period_valid[ch]               = pv_q;
    assign avg_valid[ch]                  = av_q;
    assign stalled[ch]                    = st_q;
  end

endmodule
